multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock, `clk`; reset SHALL be `rst`, asynchronous and active-high.
REQ-002 Ports (name, direction, width, meaning), in order:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  instruction[31:26] from the external instruction register (IR)
- funct  in  6  instruction[5:0] from the external IR
- alu_zero  in  1  ALU result == 0
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  capture instruction into IR
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (1) / read (0)
- pc_write  out  1  update PC
- pc_sel  out  2  next-PC source: 00 pc+4, 01 branch target, 10 jump target, 11 register rs
- rf_we  out  1  register file write enable
- rf_dst_sel  out  2  destination register: 00 rt, 01 rd, 10 $31
- rf_src_sel  out  2  write-back data: 00 ALU, 01 memory, 10 pc+4
- alu_src  out  1  ALU B operand: 0 rt, 1 sign-extended immediate
- alu_ctrl  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sll
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky unsupported-encoding flag
- instr_count  out  32  count of retired instructions

Function
REQ-003 The block SHALL be a state machine with the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 IDLE SHALL move to FETCH on start=1; otherwise it SHALL hold.
REQ-005 In FETCH, imem_req SHALL be 1 and SHALL stay 1 until imem_ack=1. On the ack cycle:
- ir_load=1
- pc_write=1 with pc_sel=00
- next state DECODE
REQ-006 opcode and funct SHALL be sampled only in DECODE and later states (IR is valid from the cycle after ir_load).
REQ-007 DECODE SHALL go to HALT for opcode 111111 and to EXEC for every other opcode.
REQ-008 EXEC SHALL behave per opcode:
- R-type (000000): alu_src=0, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll), next state WB.
- jr (funct 001000): pc_write=1, pc_sel=11, next state FETCH.
- addi (001000): alu_src=1, alu_ctrl=0000, next state WB.
- lw (100011) / sw (101011): alu_src=1, alu_ctrl=0000, next state MEM.
- beq (000100) / bne (000101): alu_ctrl=0001; pc_write=1 with pc_sel=01 only if alu_zero matches the condition (1 for beq, 0 for bne); next state FETCH.
- j (000010): pc_write=1, pc_sel=10, next state FETCH.
- jal (000011): pc_write=1, pc_sel=10, rf_we=1, rf_dst_sel=10, rf_src_sel=10, next state FETCH.
REQ-009 In MEM, dmem_req SHALL be 1 until dmem_ack=1:
- sw: dmem_we=1, next state FETCH on ack.
- lw: dmem_we=0, next state WB on ack.
REQ-010 WB SHALL assert rf_we=1 for exactly one cycle, then go to FETCH:
- R-type: rf_dst_sel=01, rf_src_sel=00.
- addi: rf_dst_sel=00, rf_src_sel=00.
- lw: rf_dst_sel=00, rf_src_sel=01.
REQ-011 An unsupported opcode, or an unsupported funct with R-type, seen in EXEC SHALL:
- set illegal=1 (sticky until reset);
- assert no write enable;
- go to HALT.
REQ-012 HALT SHALL hold until reset; start SHALL be ignored in HALT.
REQ-013 When an output is not specified for a state, it SHALL be 0.
REQ-014 instr_count SHALL increment by 1 on the final cycle of each retired instruction (the transition into FETCH from EXEC, MEM or WB), wrapping from FFFFFFFF to 0; halt and illegal instructions SHALL not count.
REQ-015 Cycle counts with zero-wait acks SHALL be: R-type/addi 4, lw 5, sw 4, branch/jump 3.
REQ-016 An imem_ack or dmem_ack received outside its wait state SHALL be ignored.

Reset
REQ-017 rst=1 SHALL force IDLE immediately, without waiting for a clock edge, including mid-operation and mid-handshake.
REQ-018 Under reset, every output SHALL be 0: instr_count=0, illegal=0, halted=0, busy=0.
REQ-019 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-020 Sequence add (000000/100000) → lw (100011) → sw (101011), with imem_ack and dmem_ack held at 1. Required response:
- state trace: F,D,E,W, F,D,E,M,W, F,D,E,M;
- rf_we pulses with rf_dst_sel=01 then 00;
- instr_count=3.
REQ-021 beq with alu_zero=1 → pc_write=1, pc_sel=01 in EXEC. bne with alu_zero=1 → pc_write=0 in EXEC. Both return to FETCH after 3 cycles.
REQ-022 jal → in EXEC: rf_we=1, rf_dst_sel=10, rf_src_sel=10, pc_sel=10. jr (funct 001000) → in EXEC: pc_sel=11, rf_we=0.
REQ-023 imem_ack delayed 5 cycles → imem_req held for 6 cycles, ir_load exactly 1 cycle. dmem_ack delayed 3 cycles on lw → state held in MEM throughout.
REQ-024 Opcode 010101 → illegal=1, halted=1, no rf_we or dmem_req, instr_count unchanged. A later start=1 → ignored.
REQ-025 rst asserted mid-MEM between clock edges → all outputs 0 immediately; start=1 after release → fetch resumes.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control unit FSM
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             leave IDLE and begin fetching
//   opcode, funct     instruction fields from the external IR (valid from DECODE on)
//   alu_zero          ALU result is zero (branch condition)
//   imem_ack          instruction memory data valid
//   dmem_ack          data memory access complete
//   imem_req, ir_load instruction fetch request / IR capture strobe
//   dmem_req, dmem_we data memory request / write select
//   pc_write, pc_sel  PC update enable / next-PC source
//   rf_we, rf_dst_sel, rf_src_sel  register file write controls
//   alu_src, alu_ctrl ALU operand B select / operation
//   busy, halted      activity and halt status
//   illegal           sticky unsupported-encoding flag
//   instr_count       retired instruction counter
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  rf_dst_sel,
    output logic [1:0]  rf_src_sel,
    output logic        alu_src,
    output logic [3:0]  alu_ctrl,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t     state, next_state;
    logic       is_rtype, is_jr, r_ok, op_ok, exec_illegal, retire, br_taken;
    logic [3:0] r_ctrl;

    // Instruction classification; only consulted from DECODE onward.
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_jr    = is_rtype && (funct == FN_JR);
        r_ok     = 1'b1;
        r_ctrl   = 4'b0000;
        case (funct)
            6'b100000: r_ctrl = 4'b0000;
            6'b100010: r_ctrl = 4'b0001;
            6'b100100: r_ctrl = 4'b0010;
            6'b100101: r_ctrl = 4'b0011;
            6'b101010: r_ctrl = 4'b0100;
            6'b000000: r_ctrl = 4'b0101;
            default:   r_ok   = 1'b0;
        endcase
        case (opcode)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_ok = 1'b1;
            OP_RTYPE: op_ok = is_jr || r_ok;
            default:  op_ok = 1'b0;
        endcase
        exec_illegal = !op_ok;
        br_taken     = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH:  if (imem_ack) next_state = S_DECODE;
            S_DECODE: next_state = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (exec_illegal)                          next_state = S_HALT;
                else if (is_jr)                            next_state = S_FETCH;
                else if (is_rtype || opcode == OP_ADDI)    next_state = S_WB;
                else if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEM;
                else                                       next_state = S_FETCH;
            end
            S_MEM:    if (dmem_ack) next_state = (opcode == OP_SW) ? S_FETCH : S_WB;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 2'b00;
        rf_we      = 1'b0;
        rf_dst_sel = 2'b00;
        rf_src_sel = 2'b00;
        alu_src    = 1'b0;
        alu_ctrl   = 4'b0000;
        busy       = (state != S_IDLE) && (state != S_HALT);
        halted     = (state == S_HALT);
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                pc_write = imem_ack;
            end
            S_EXEC: begin
                if (!exec_illegal) begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (is_jr) begin
                                pc_write = 1'b1;
                                pc_sel   = 2'b11;
                            end else begin
                                alu_ctrl = r_ctrl;
                            end
                        end
                        OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
                        OP_BEQ, OP_BNE: begin
                            alu_ctrl = 4'b0001;
                            pc_write = br_taken;
                            pc_sel   = br_taken ? 2'b01 : 2'b00;
                        end
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_sel   = 2'b10;
                        end
                        OP_JAL: begin
                            pc_write   = 1'b1;
                            pc_sel     = 2'b10;
                            rf_we      = 1'b1;
                            rf_dst_sel = 2'b10;
                            rf_src_sel = 2'b10;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
            end
            S_WB: begin
                rf_we = 1'b1;
                if (is_rtype)              rf_dst_sel = 2'b01;
                if (opcode == OP_LW)       rf_src_sel = 2'b01;
            end
            default: ;
        endcase
    end

    // An instruction retires on the cycle that hands control back to FETCH.
    assign retire = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB))
                    && (next_state == S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal     <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            if (state == S_EXEC && exec_illegal) illegal <= 1'b1;
            if (retire) instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized trace-model bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst, start, alu_zero, imem_ack, dmem_ack;
    logic [5:0]  opcode, funct;
    logic        imem_req, ir_load, dmem_req, dmem_we, pc_write, rf_we, alu_src;
    logic        busy, halted, illegal;
    logic [1:0]  pc_sel, rf_dst_sel, rf_src_sel;
    logic [3:0]  alu_ctrl;
    logic [31:0] instr_count;

    multicycle_control dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_write(pc_write), .pc_sel(pc_sel), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel),
        .rf_src_sel(rf_src_sel), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: inputs to apply and outputs required.
    typedef struct {
        bit        st, ia, da, az;
        bit [5:0]  op, fn;
        bit [19:0] exp;
        bit [31:0] cnt;
    } cyc_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cycno = 0;
    bit [31:0]   m_cnt = 0;
    bit          m_ill = 0;
    bit [5:0]    r_fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};
    bit [5:0]    ops [10] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    wire [19:0] obs = {imem_req, ir_load, dmem_req, dmem_we, pc_write, pc_sel, rf_we,
                       rf_dst_sel, rf_src_sel, alu_src, alu_ctrl, busy, halted, illegal};

    function automatic bit rb();
        return ($urandom & 1) != 0;
    endfunction

    function automatic bit [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic bit [19:0] ov(bit ireq, bit irl, bit dreq, bit dwe, bit pcw,
                                     bit [1:0] pcs, bit rfwe, bit [1:0] dst, bit [1:0] src,
                                     bit asrc, bit [3:0] actl, bit bsy, bit hlt);
        return {ireq, irl, dreq, dwe, pcw, pcs, rfwe, dst, src, asrc, actl, bsy, hlt, 1'b0};
    endfunction

    task automatic push(bit st, bit ia, bit da, bit az, bit [5:0] op, bit [5:0] fn, bit [19:0] e);
        cyc_t c;
        c.st = st; c.ia = ia; c.da = da; c.az = az; c.op = op; c.fn = fn;
        c.exp = e | {19'd0, m_ill};
        c.cnt = m_cnt;
        q.push_back(c);
    endtask

    task automatic idle(int n, bit st);
        for (int i = 0; i < n; i++)
            push(st, rb(), rb(), rb(), r6(), r6(), ov(0,0,0,0,0,0,0,0,0,0,0,0,0));
    endtask

    task automatic halt_cycles(int n);
        for (int i = 0; i < n; i++)
            push(1'b1, rb(), rb(), rb(), r6(), r6(), ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
    endtask

    // Expands one instruction into its cycle-by-cycle expected trace.
    task automatic gen(bit [5:0] op, bit [5:0] fn, bit az, int idly, int ddly);
        bit [3:0] actl;
        bit       ok, tk;
        for (int i = 0; i < idly; i++)
            push(rb(), 1'b0, rb(), rb(), r6(), r6(), ov(1,0,0,0,0,0,0,0,0,0,0,1,0));
        push(rb(), 1'b1, rb(), rb(), r6(), r6(), ov(1,1,0,0,1,0,0,0,0,0,0,1,0));
        push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
        if (op == 6'h3F) return;
        case (op)
            6'h00: begin
                ok = 1'b1;
                case (fn)
                    6'h20: actl = 4'd0;
                    6'h22: actl = 4'd1;
                    6'h24: actl = 4'd2;
                    6'h25: actl = 4'd3;
                    6'h2A: actl = 4'd4;
                    6'h00: actl = 4'd5;
                    default: begin actl = 4'd0; ok = 1'b0; end
                endcase
                if (fn == 6'h08) begin
                    push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,1,3,0,0,0,0,0,1,0));
                    m_cnt++;
                end else if (ok) begin
                    push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,0,actl,1,0));
                    push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,1,1,0,0,0,1,0));
                    m_cnt++;
                end else begin
                    push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
                    m_ill = 1'b1;
                end
            end
            6'h08: begin
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,1,0,1,0));
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,1,0,0,0,0,1,0));
                m_cnt++;
            end
            6'h23, 6'h2B: begin
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,1,0,1,0));
                for (int i = 0; i < ddly; i++)
                    push(rb(), rb(), 1'b0, rb(), op, fn, ov(0,0,1,op == 6'h2B,0,0,0,0,0,0,0,1,0));
                push(rb(), rb(), 1'b1, rb(), op, fn, ov(0,0,1,op == 6'h2B,0,0,0,0,0,0,0,1,0));
                if (op == 6'h23)
                    push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,1,0,1,0,0,1,0));
                m_cnt++;
            end
            6'h04, 6'h05: begin
                tk = (op == 6'h04) ? az : !az;
                push(rb(), rb(), rb(), az, op, fn, ov(0,0,0,0,tk,tk ? 2'd1 : 2'd0,0,0,0,0,1,1,0));
                m_cnt++;
            end
            6'h02: begin
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,1,2,0,0,0,0,0,1,0));
                m_cnt++;
            end
            6'h03: begin
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,1,2,1,2,2,0,0,1,0));
                m_cnt++;
            end
            default: begin
                push(rb(), rb(), rb(), rb(), op, fn, ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
                m_ill = 1'b1;
            end
        endcase
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.st; imem_ack = c.ia; dmem_ack = c.da; alu_zero = c.az;
            opcode = c.op; funct = c.fn;
            @(negedge clk);
            total++;
            assert (obs === c.exp) else begin
                bad++;
                $error("FAIL outs cyc=%0d observed=%05h expected=%05h", cycno, obs, c.exp);
            end
            total++;
            assert (instr_count === c.cnt) else begin
                bad++;
                $error("FAIL count cyc=%0d observed=%0d expected=%0d", cycno, instr_count, c.cnt);
            end
            cycno++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = 6'h00; funct = 6'h00;
        #12;
        total++;
        assert (obs === 20'd0 && instr_count === 32'd0) else begin
            bad++;
            $error("FAIL reset_state observed=%05h/%0d expected=00000/0", obs, instr_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        idle(3, 1'b0);
        idle(1, 1'b1);
        gen(6'h00, 6'h20, 1'b0, 0, 0);
        gen(6'h23, r6(), 1'b0, 0, 0);
        gen(6'h2B, r6(), 1'b0, 0, 0);
        gen(6'h04, r6(), 1'b1, 0, 0);
        gen(6'h05, r6(), 1'b1, 0, 0);
        gen(6'h03, r6(), 1'b0, 0, 0);
        gen(6'h00, 6'h08, 1'b0, 0, 0);
        gen(6'h23, r6(), 1'b0, 5, 3);
        for (int i = 0; i < 40; i++) begin
            bit [5:0] op;
            bit [5:0] fn;
            op = ops[$urandom_range(9, 0)];
            fn = (op == 6'h00) ? r_fn[$urandom_range(6, 0)] : r6();
            gen(op, fn, rb(), $urandom_range(3, 0), $urandom_range(3, 0));
        end
        gen(6'h15, r6(), 1'b0, 1, 0);
        halt_cycles(4);
        run_q();

        // Reset asserted between edges while a load waits in MEM.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        m_cnt = 0; m_ill = 1'b0;
        idle(1, 1'b1);
        gen(6'h00, 6'h25, 1'b0, 0, 0);
        gen(6'h23, r6(), 1'b0, 0, 2);
        void'(q.pop_back());
        void'(q.pop_back());
        run_q();
        #3;
        rst = 1'b1;
        #1;
        total++;
        assert (obs === 20'd0 && instr_count === 32'd0) else begin
            bad++;
            $error("FAIL async_reset observed=%05h/%0d expected=00000/0", obs, instr_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_ill = 1'b0;
        idle(2, 1'b0);
        idle(1, 1'b1);
        gen(6'h08, r6(), 1'b0, 2, 0);
        gen(6'h3F, r6(), 1'b0, 0, 0);
        halt_cycles(3);
        run_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
